hilo_unit: RTL and testbench

//   Sequencer and architectural HI/LO register file around the 32x32 signed Booth multiplier (mult).

---
 rtl/hilo_unit_pkg.sv | 15 +
 rtl/hilo_unit.sv | 117 +++++++++++
 tb/tb_hilo_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencers.
package hilo_unit_pkg;

    localparam int HILO_WIDTH    = 32;
    localparam int HILO_MULT_LAT = 36;
    localparam int HILO_CNT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit.sv
// MULT sequencer and architectural HI/LO registers wrapped around the Booth multiplier.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH    = HILO_WIDTH,
    parameter int MULT_LAT = HILO_MULT_LAT,
    parameter int CNT_W    = HILO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic             mult_init,
    output logic             mult_stop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    hilo_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] a_d, b_d, hi_d, lo_d;
    logic             init_d, stop_d, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mult_a    <= '0;
            mult_b    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mult_init <= 1'b0;
            mult_stop <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mult_a    <= a_d;
            mult_b    <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mult_init <= init_d;
            mult_stop <= stop_d;
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
        end
    end

    // Pulses are computed for the next state so they leave the flops clean.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = mult_a;
        b_d     = mult_b;
        hi_d    = hi_q;
        lo_d    = lo_q;
        init_d  = 1'b0;
        stop_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    init_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    stop_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(MULT_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    stop_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt == '0) begin
                    // Product is latched on entry so HI/LO are valid while done is high.
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
                    done_d  = 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a cycle-age reference model.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 36;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] mult_hi, mult_lo, mult_a, mult_b, hi_q, lo_q;
    logic         mult_init, mult_stop, busy, done;

    always #5 clk = ~clk;

    // Idealised multiplier: product of the held operands.
    assign {mult_hi, mult_lo} =
        64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));

    hilo_unit #(.WIDTH(W), .MULT_LAT(LAT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init),
        .mult_stop(mult_stop), .busy(busy), .done(done),
        .hi_q(hi_q), .lo_q(lo_q)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Model: k = cycles since accept (-1 when idle).
    int           k = -1;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    bit           m_stop = 1'b0;

    int           cyc = 0;
    int           n_init, n_stop, n_done, n_busy;
    int           last_done_cyc = -100;
    int           b2b_gap = -1;
    logic [W-1:0] done_hi, done_lo;
    bit           dead_seen;

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [63:0] p;
        m_stop = 1'b0;
        if (!rst) begin
            k = -1;
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
        end else if (k < 0) begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (start) begin
                m_a = op_a;
                m_b = op_b;
                k = 0;
            end
        end else if (k == LAT + 1) begin
            k = -1;
        end else if (abort) begin
            k = -1;
            m_stop = 1'b1;
        end else begin
            k++;
            if (k == LAT + 1) begin
                p = 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chkb("busy", busy, k >= 0);
        chkb("init", mult_init, k == 0);
        chkb("done", done, k == LAT + 1);
        chkb("stop", mult_stop, m_stop);
        chkw("hi_q", hi_q, m_hi);
        chkw("lo_q", lo_q, m_lo);
        chkw("mult_a", mult_a, m_a);
        chkw("mult_b", mult_b, m_b);
        if (mult_init) begin
            n_init++;
            if (b2b_gap < 0 && last_done_cyc > 0) b2b_gap = cyc - last_done_cyc;
        end
        if (mult_stop) n_stop++;
        if (busy) n_busy++;
        if (busy && !done && hi_q == 32'hDEAD) dead_seen = 1'b1;
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
            done_hi = hi_q;
            done_lo = lo_q;
        end
    endtask

    task automatic clr();
        n_init = 0; n_stop = 0; n_done = 0; n_busy = 0;
        dead_seen = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (k >= 0 && n < bound) begin
            step();
            n++;
        end
        chkb("idle_bound", busy, 1'b0);
    endtask

    initial begin
        clr();
        // Reset
        rst = 1'b0;
        step();
        step();
        chkw("rst_hi", hi_q, 32'h0);
        chkb("rst_busy", busy, 1'b0);
        rst = 1'b1;
        step();

        // Basic multiply
        clr();
        start = 1'b1; op_a = 32'd7; op_b = 32'd6;
        step();
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        run_idle(60);
        chki("mul_init_cnt", n_init, 1);
        chki("mul_done_cnt", n_done, 1);
        chki("mul_busy_span", n_busy, LAT + 2);
        chkw("mul_hi", done_hi, 32'h0);
        chkw("mul_lo", done_lo, 32'd42);

        // Negative product
        clr();
        start = 1'b1; op_a = -32'sd3; op_b = 32'd5;
        step();
        start = 1'b0;
        run_idle(60);
        chkw("neg_hi", done_hi, 32'hFFFF_FFFF);
        chkw("neg_lo", done_lo, 32'hFFFF_FFF1);

        // Hazards while busy
        clr();
        start = 1'b1; op_a = 32'd1; op_b = 32'd4;
        step();
        start = 1'b0;
        step();
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
        hi_we = 1'b1; wdata = 32'hDEAD;
        repeat (3) step();
        start = 1'b0; hi_we = 1'b0;
        chkw("haz_a", mult_a, 32'd1);
        chkw("haz_b", mult_b, 32'd4);
        run_idle(60);
        chkw("haz_lo", done_lo, 32'd4);
        chkw("haz_hi", done_hi, 32'h0);
        chki("haz_dead", int'(dead_seen), 0);

        // Abort in WAIT
        hi_we = 1'b1; wdata = 32'd5;
        step();
        hi_we = 1'b0;
        clr();
        start = 1'b1; op_a = $urandom; op_b = $urandom;
        step();
        start = 1'b0;
        repeat (10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_stop", mult_stop, 1'b1);
        repeat (50) step();
        chki("abort_stop_cnt", n_stop, 1);
        chki("abort_done_cnt", n_done, 0);
        chkw("abort_hi", hi_q, 32'd5);

        // Reset mid-WAIT
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op_a = $urandom; op_b = $urandom;
        step();
        start = 1'b0;
        repeat (15) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chkb("rstw_busy", busy, 1'b0);
        chkw("rstw_hi", hi_q, 32'h0);
        chkw("rstw_lo", lo_q, 32'h0);
        clr();
        repeat (50) step();
        chki("rstw_init", n_init, 0);
        chki("rstw_stop", n_stop, 0);
        chki("rstw_done", n_done, 0);

        // Back-to-back with start held
        clr();
        last_done_cyc = -100;
        b2b_gap = -1;
        start = 1'b1; op_a = $urandom; op_b = $urandom;
        for (int i = 0; i < 200 && n_done < 2; i++) step();
        start = 1'b0;
        run_idle(60);
        chki("b2b_done_cnt", n_done, 2);
        chki("b2b_gap", b2b_gap, 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            start = ($urandom % 4) == 0;
            abort = ($urandom % 24) == 0;
            hi_we = ($urandom % 6) == 0;
            lo_we = ($urandom % 6) == 0;
            wdata = $urandom;
            op_a  = $urandom;
            op_b  = $urandom;
            rst   = ($urandom % 200) != 0;
            step();
        end
        start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rst = 1'b1;
        run_idle(60);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
